subtraction: RTL and testbench

Unsigned 32-bit subtractor for the RISC-V PE datapath. It computes Diff = A − B modulo 2^WIDTH and flags an unsigned borrow (A < B). The arithmetic core is a combinational ripple-borrow chain. The result and flag are registered once, so the ALU result mux sees a clean one-cycle-latency output.

---
 rtl/subtraction_pkg.sv | 6 +
 rtl/subtraction_if.sv | 27 ++
 rtl/subtraction_full_subtractor.sv | 13 +
 rtl/subtraction.sv | 43 ++++
 tb/tb_subtraction.sv | 116 +++++++++++
 5 files changed

// File: rtl/subtraction_pkg.sv
// Shared datapath constants for the PE subtractor.
package subtraction_pkg;

   localparam int unsigned DATA_WIDTH = 32;

endpackage : subtraction_pkg

// File: rtl/subtraction_if.sv
// Operand/result bundle between the ALU operand source and the subtractor.
interface subtraction_if
   import subtraction_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_WIDTH
);

   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] Diff;
   logic             Borrow;

   modport master (
      output A,
      output B,
      input  Diff,
      input  Borrow
   );

   modport slave (
      input  A,
      input  B,
      output Diff,
      output Borrow
   );

endinterface : subtraction_if

// File: rtl/subtraction_full_subtractor.sv
// One-bit full subtractor: the cell of the ripple-borrow chain.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor

// File: rtl/subtraction.sv
// Unsigned WIDTH-bit subtractor: ripple-borrow core, registered Diff/Borrow.
module subtraction
   import subtraction_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   subtraction_if.slave bus
);

   logic [WIDTH:0]   w_borrow;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow;

   assign w_borrow[0] = 1'b0;

   // Ripple chain kept deliberately; it is the intended critical path.
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_subtractor u_fs (
         .a    (bus.A[i]),
         .b    (bus.B[i]),
         .bin  (w_borrow[i]),
         .d    (w_diff[i]),
         .bout (w_borrow[i+1])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_diff   <= '0;
         r_borrow <= 1'b0;
      end else begin
         r_diff   <= w_diff;
         r_borrow <= w_borrow[WIDTH];
      end
   end

   assign bus.Diff   = r_diff;
   assign bus.Borrow = r_borrow;

endmodule : subtraction

// File: tb/tb_subtraction.sv
// Directed and random checks of the registered unsigned subtractor.
module tb_subtraction;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   subtraction_if #(.WIDTH(32)) bus ();

   subtraction #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] exp_d, input logic exp_b);
      checks++;
      assert ({bus.Borrow, bus.Diff} === {exp_b, exp_d})
      else begin
         errors++;
         $error("FAIL %s: got Diff=%h Borrow=%b expected Diff=%h Borrow=%b",
                tag, bus.Diff, bus.Borrow, exp_d, exp_b);
      end
   endtask

   // Drive a pair and sample one ns after the capturing edge.
   task automatic apply(input logic [31:0] a, input logic [31:0] b);
      bus.A = a;
      bus.B = b;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] pa [8];
   logic [31:0] pb [8];
   logic [31:0] ra;
   logic [31:0] rb;

   initial begin
      checks = 0;
      errors = 0;

      // Reset behaviour
      rst   = 1'b1;
      bus.A = 32'd15;
      bus.B = 32'd5;
      #2;
      check("reset_no_clk", 32'd0, 1'b0);
      @(posedge clk); #1;
      check("reset_hold", 32'd0, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("reset_release", 32'd10, 1'b0);

      // Basic, borrow, identities, wrap
      apply(32'd15, 32'd5);                check("basic", 32'd10, 1'b0);
      apply(32'd5, 32'd15);                check("borrow", 32'hFFFF_FFF6, 1'b1);
      apply(32'd20, 32'd0);                check("b_zero", 32'd20, 1'b0);
      apply(32'd25, 32'd25);               check("a_eq_b", 32'd0, 1'b0);
      apply(32'd0, 32'd0);                 check("both_zero", 32'd0, 1'b0);
      apply(32'hFFFF_FFF0, 32'h0000_000F); check("large", 32'hFFFF_FFE1, 1'b0);
      apply(32'h0000_0001, 32'hFFFF_FFFF); check("wrap", 32'h0000_0002, 1'b1);
      apply(32'h8000_0000, 32'h0000_0001); check("msb_chain", 32'h7FFF_FFFF, 1'b0);
      apply(32'h0000_0000, 32'h0000_0001); check("all_borrow", 32'hFFFF_FFFF, 1'b1);

      // Async reset mid-stream discards the held result
      apply(32'd100, 32'd1);               check("pre_rst", 32'd99, 1'b0);
      #2 rst = 1'b1;
      #1 check("async_mid", 32'd0, 1'b0);
      @(posedge clk); #1;
      check("rst_held", 32'd0, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst", 32'd99, 1'b0);

      // Inputs changed between edges must not reach the outputs
      apply(32'd7, 32'd3);                 check("toggle_pre", 32'd4, 1'b0);
      #2;
      bus.A = 32'd1000;
      bus.B = 32'd1;
      #1 check("toggle_hold", 32'd4, 1'b0);
      @(posedge clk); #1;
      check("toggle_next", 32'd999, 1'b0);

      // Back-to-back: each edge shows the pair applied just before it
      pa = '{32'd1, 32'd300, 32'hDEAD_BEEF, 32'd0, 32'd42, 32'hFFFF_FFFF, 32'd9, 32'h1234_5678};
      pb = '{32'd2, 32'd299, 32'h0BAD_F00D, 32'd7, 32'd42, 32'd1, 32'd10, 32'h1234_5677};
      for (int k = 0; k < 8; k++) begin
         apply(pa[k], pb[k]);
         check("pipe", 32'(pa[k] - pb[k]), pa[k] < pb[k]);
      end

      // Random pairs with occasional asynchronous reset pulses
      for (int i = 0; i < 10000; i++) begin
         ra = $urandom;
         rb = (i % 16 == 0) ? ra : $urandom;
         bus.A = ra;
         bus.B = rb;
         if ($urandom_range(0, 49) == 0) begin
            #1 rst = 1'b1;
            #1 check("rand_rst", 32'd0, 1'b0);
            #1 rst = 1'b0;
         end
         @(posedge clk); #1;
         check("rand", 32'(ra - rb), ra < rb);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_subtraction
